// File: rtl/spi_master_param.sv
// Parametrised SPI master: divided SCLK, per-transfer CPOL/CPHA, one-hot
// active-low chip select and a start/busy/done host handshake.
module spi_master_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int SLAVE_COUNT = 4,
  parameter int CLK_DIV     = 4,
  parameter bit MSB_FIRST   = 1'b1,
  localparam int SEL_W = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SEL_W-1:0]       slaveSelect,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic [DATA_WIDTH-1:0]  masterDataToSend,
  output logic [DATA_WIDTH-1:0]  masterDataReceived,
  output logic                   busy,
  output logic                   done,
  output logic                   SCLK,
  output logic [SLAVE_COUNT-1:0] CS,
  output logic                   MOSI,
  input  logic                   MISO
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } cfg_t;

  state_t                state;
  cfg_t                  cfg;
  logic [DIV_W-1:0]      divCnt;
  logic [EDGE_W-1:0]     edgeCnt;
  logic [DATA_WIDTH-1:0] txShift;
  logic [DATA_WIDTH-1:0] rxShift;
  logic                  divEnd;
  logic                  startOk;

  assign divEnd  = (divCnt == DIV_W'(CLK_DIV - 1));
  assign startOk = start && !busy && (int'(slaveSelect) < SLAVE_COUNT);

  function automatic logic outBit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shiftOut(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shiftIn(input logic [DATA_WIDTH-1:0] w,
                                                    input logic b);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      cfg                <= '0;
      divCnt             <= '0;
      edgeCnt            <= '0;
      txShift            <= '0;
      rxShift            <= '0;
      masterDataReceived <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      SCLK               <= 1'b0;
      CS                 <= '1;
      MOSI               <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (startOk) begin
            state   <= SETUP;
            busy    <= 1'b1;
            cfg     <= '{cpol: cpol, cpha: cpha};
            divCnt  <= '0;
            edgeCnt <= '0;
            rxShift <= '0;
            SCLK    <= cpol;
            CS      <= ~(SLAVE_COUNT'(1) << slaveSelect);
            // cpha=0 slaves sample on the first edge, so bit 0 must already be out
            if (!cpha) begin
              MOSI    <= outBit(masterDataToSend);
              txShift <= shiftOut(masterDataToSend);
            end else begin
              MOSI    <= 1'b0;
              txShift <= masterDataToSend;
            end
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          divCnt <= divEnd ? '0 : divCnt + 1'b1;
          if (divEnd) state <= XFER;
        end
        XFER: begin
          divCnt <= divEnd ? '0 : divCnt + 1'b1;
          if (divEnd) begin
            SCLK    <= ~SCLK;
            edgeCnt <= edgeCnt + 1'b1;
            if (!edgeCnt[0]) begin
              if (!cfg.cpha) begin
                rxShift <= shiftIn(rxShift, MISO);
              end else begin
                MOSI    <= outBit(txShift);
                txShift <= shiftOut(txShift);
              end
            end else begin
              if (cfg.cpha) begin
                rxShift <= shiftIn(rxShift, MISO);
              end else if (edgeCnt != LAST_EDGE) begin
                MOSI    <= outBit(txShift);
                txShift <= shiftOut(txShift);
              end
              if (edgeCnt == LAST_EDGE) state <= HOLD;
            end
          end
        end
        HOLD: begin
          divCnt <= divEnd ? '0 : divCnt + 1'b1;
          if (divEnd) begin
            state              <= DONE;
            busy               <= 1'b0;
            done               <= 1'b1;
            CS                 <= '1;
            MOSI               <= 1'b0;
            SCLK               <= cfg.cpol;
            masterDataReceived <= rxShift;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: default build with a mode-0 slave model
// and loopback, a 3-slave build for range rejection, and a 16-bit LSB-first build.
module tb_spi_master_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int nCmp = 0;
  int nFail = 0;

  // default build
  logic       start0 = 0, pol0 = 0, pha0 = 0, loop0 = 0;
  logic [1:0] sel0 = 0;
  logic [7:0] data0 = 0, rx0;
  logic       busy0, done0, sclk0, mosi0, miso0;
  logic [3:0] cs0;
  logic [7:0] slvTx = 0, slvRx = 0;
  logic [15:0] q0[$];

  // three-slave build
  logic       start1 = 0;
  logic [1:0] sel1 = 0;
  logic [7:0] rx1;
  logic       busy1, done1, sclk1, mosi1;
  logic [2:0] cs1;

  // 16-bit LSB-first build
  logic        start2 = 0;
  logic [15:0] data2 = 0, rx2;
  logic        busy2, done2, sclk2, mosi2;
  logic [3:0]  cs2;
  logic [15:0] q2[$];

  assign miso0 = loop0 ? mosi0 : slvTx[7];

  spi_master_param u0 (
    .clk(clk), .reset(reset), .start(start0), .slaveSelect(sel0), .cpol(pol0), .cpha(pha0),
    .masterDataToSend(data0), .masterDataReceived(rx0), .busy(busy0), .done(done0),
    .SCLK(sclk0), .CS(cs0), .MOSI(mosi0), .MISO(miso0));

  spi_master_param #(.SLAVE_COUNT(3)) u1 (
    .clk(clk), .reset(reset), .start(start1), .slaveSelect(sel1), .cpol(1'b0), .cpha(1'b0),
    .masterDataToSend(8'h77), .masterDataReceived(rx1), .busy(busy1), .done(done1),
    .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(mosi1));

  spi_master_param #(.DATA_WIDTH(16), .MSB_FIRST(1'b0), .CLK_DIV(1)) u2 (
    .clk(clk), .reset(reset), .start(start2), .slaveSelect(2'd0), .cpol(1'b0), .cpha(1'b0),
    .masterDataToSend(data2), .masterDataReceived(rx2), .busy(busy2), .done(done2),
    .SCLK(sclk2), .CS(cs2), .MOSI(mosi2), .MISO(mosi2));

  // existing mode-0 8-bit slave, on CS[0]
  always @(posedge sclk0) if (!cs0[0]) slvRx <= {slvRx[6:0], mosi0};
  always @(negedge sclk0) if (!cs0[0]) slvTx <= {slvTx[6:0], 1'b0};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboards: a done with nothing queued compares against X and fails
  always @(negedge clk) if (reset && done0) begin
    logic [15:0] e;
    e = (q0.size() != 0) ? q0.pop_front() : 16'hxxxx;
    check("u0 received", 16'(rx0), e);
  end
  always @(negedge clk) if (reset && done2) begin
    logic [15:0] e;
    e = (q2.size() != 0) ? q2.pop_front() : 16'hxxxx;
    check("u2 received", rx2, e);
  end

  task automatic drive(input logic [1:0] sel, input logic pol, input logic pha,
                       input logic [7:0] data, input logic [7:0] exp);
    @(negedge clk);
    sel0 = sel; pol0 = pol; pha0 = pha; data0 = data; start0 = 1'b1;
    q0.push_back(16'(exp));
    @(negedge clk);
    start0 = 1'b0;
  endtask

  // Called at the negedge of cycle 1 of a transfer; optionally pokes a start
  // mid-transfer and chains a back-to-back start in the done cycle.
  task automatic watch(input logic [1:0] sel, input logic pol, input int poke,
                       input bit chain, input logic [7:0] chainData);
    int doneAt = 0, lead = 0, trail = 0;
    bit busyOk = 1, csOk = 1, idleOk = 1;
    logic prev;
    logic [3:0] expCs;
    expCs = ~(4'b0001 << sel);
    prev = sclk0;
    for (int n = 1; n <= 100 && doneAt == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (sclk0 != prev) begin
        if (sclk0 != pol) lead++; else trail++;
        prev = sclk0;
      end
      if (done0) doneAt = n;
      else begin
        if (busy0 !== 1'b1) busyOk = 0;
        if (cs0 !== expCs) csOk = 0;
      end
      if ((n <= 4 || done0) && sclk0 !== pol) idleOk = 0;
      if (n == poke) begin
        start0 = 1'b1; sel0 = sel ^ 2'd1; data0 = 8'hFF;
      end else if (n == poke + 1) begin
        start0 = 1'b0; sel0 = sel;
      end
    end
    check("done cycle", 16'(doneAt), 16'd73);
    check("leading edges", 16'(lead), 16'd8);
    check("trailing edges", 16'(trail), 16'd8);
    check("busy 1..72", 16'(busyOk), 16'd1);
    check("cs during xfer", 16'(csOk), 16'd1);
    check("sclk idle level", 16'(idleOk), 16'd1);
    check("cs in done", 16'(cs0), 16'hF);
    check("mosi in done", 16'(mosi0), 16'd0);
    if (chain) begin
      data0 = chainData; start0 = 1'b1;
      q0.push_back(16'(chainData));
      @(negedge clk);
      start0 = 1'b0;
    end
  endtask

  initial begin
    int bad, doneAt;
    repeat (2) @(negedge clk);
    check("rst cs", 16'(cs0), 16'hF);
    check("rst sclk", 16'(sclk0), 16'd0);
    check("rst mosi", 16'(mosi0), 16'd0);
    check("rst busy", 16'(busy0), 16'd0);
    check("rst done", 16'(done0), 16'd0);
    check("rst rx", 16'(rx0), 16'd0);
    reset = 1'b1;

    // mode 0 against the slave model
    loop0 = 0; slvTx = 8'h09;
    drive(2'd0, 0, 0, 8'h53, 8'h09);
    watch(2'd0, 0, -1, 0, 8'h00);
    check("slave received", 16'(slvRx), 16'h53);

    // loopback mode sweep
    loop0 = 1;
    for (int m = 0; m < 4; m++) begin
      drive(2'd0, m[1], m[0], 8'hA5, 8'hA5);
      watch(2'd0, m[1], -1, 0, 8'h00);
    end

    // chip-select decode
    drive(2'd2, 0, 0, 8'h66, 8'h66);
    watch(2'd2, 0, -1, 0, 8'h00);
    drive(2'd3, 1, 1, 8'hC3, 8'hC3);
    watch(2'd3, 1, -1, 0, 8'h00);

    // ignored mid-transfer start, then back-to-back start in the done cycle
    drive(2'd1, 0, 1, 8'h5A, 8'h5A);
    watch(2'd1, 0, 20, 1, 8'h3C);
    watch(2'd1, 0, -1, 0, 8'h00);

    // asynchronous reset after three bits
    drive(2'd0, 1, 0, 8'hFF, 8'hFF);
    repeat (29) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst cs", 16'(cs0), 16'hF);
    check("arst sclk", 16'(sclk0), 16'd0);
    check("arst mosi", 16'(mosi0), 16'd0);
    check("arst busy", 16'(busy0), 16'd0);
    check("arst done", 16'(done0), 16'd0);
    check("arst rx", 16'(rx0), 16'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(2'd0, 0, 0, 8'h5A, 8'h5A);
    watch(2'd0, 0, -1, 0, 8'h00);

    // out-of-range select on the three-slave build
    @(negedge clk);
    sel1 = 2'd3; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    bad = 0;
    for (int n = 0; n < 80; n++) begin
      if (cs1 !== 3'b111 || busy1 !== 1'b0 || done1 !== 1'b0) bad++;
      @(negedge clk);
    end
    check("u1 bad select ignored", 16'(bad), 16'd0);
    check("u1 cs", 16'(cs1), 16'h7);

    // 16-bit LSB-first, single-cycle half period
    data2 = 16'h8001; start2 = 1'b1;
    q2.push_back(16'h8001);
    @(negedge clk);
    start2 = 1'b0;
    check("u2 first mosi bit", 16'(mosi2), 16'd1);
    doneAt = 0;
    for (int n = 1; n <= 60 && doneAt == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (done2) doneAt = n;
    end
    check("u2 done cycle", 16'(doneAt), 16'd35);

    repeat (5) @(negedge clk);
    check("u0 queue drained", 16'(q0.size()), 16'd0);
    check("u2 queue drained", 16'(q2.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master, the counterpart and successor to the team's fixed 8-bit mode-0 SPI slave. It runs from one system clock, divides it down to generate SCLK, and drives one of SLAVE_COUNT active-low chip selects. Per transfer it supports all four CPOL/CPHA modes, a configurable word width and a selectable bit order. A start/busy/done handshake lets a host controller issue back-to-back words.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
SLAVE_COUNT, 4, number of chip-select outputs (>=1)
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; accepted only when busy=0
slaveSelect  input  $clog2(SLAVE_COUNT) (min 1)  target slave index, latched on start
cpol  input  1  SCLK idle level, latched on start
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on start
masterDataToSend  input  DATA_WIDTH  word to transmit, latched on start
masterDataReceived  output  DATA_WIDTH  last received word
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse
SCLK  output  1  SPI clock
CS  output  SLAVE_COUNT  active-low chip selects
MOSI  output  1  serial data out
MISO  input  1  serial data in

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, CS all 1, SCLK=0, MOSI=0, busy=0, done=0, masterDataReceived=0. Takes effect mid-transfer with no completion pulse.
- States: IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
- IDLE: SCLK = latched cpol (0 after reset). CS all 1. MOSI=0.
- Start acceptance:
  - start=1 with busy=0 and slaveSelect<SLAVE_COUNT: latch the inputs. Next cycle: SETUP, busy=1.
  - start with an out-of-range slaveSelect: ignored. No busy, no CS, no done.
  - start while busy=1: ignored.
- SETUP: CLK_DIV cycles. CS[sel]=0, SCLK at idle. When cpha=0, MOSI presents the first bit on SETUP entry.
- XFER: 2*DATA_WIDTH SCLK edges, one every CLK_DIV cycles. Leading edge = transition away from cpol.
  - cpha=0: sample MISO on the leading edge. Shift MOSI to the next bit on the trailing edge (none after the last bit).
  - cpha=1: drive the next MOSI bit on the leading edge. Sample MISO on the trailing edge.
  - Bit order follows MSB_FIRST for both directions.
- HOLD: CLK_DIV cycles. SCLK at idle, CS[sel] still 0, MOSI holds the last bit.
- DONE: one cycle.
  - CS all 1, MOSI=0, busy=0, done=1.
  - masterDataReceived updates in this same cycle and holds until the next done or reset.
  - A start in the DONE cycle is accepted (back-to-back).
- Latency: done is asserted exactly 1 + CLK_DIV*(2*DATA_WIDTH+2) cycles after the start cycle. With defaults this is 73.
- Only the selected CS bit ever goes low. No CS glitches on IDLE/DONE transitions.
- All outputs are registered.

Test Plan:
1. Mode 0, slaveSelect=0, masterDataToSend=8'h53, slave model (existing SPI slave) preloaded 8'h09 -> masterDataReceived=8'h09, slave received 8'h53, done pulses exactly at cycle 73 after start, busy high cycles 1..72.
2. MISO looped to MOSI, data 8'hA5, cpol/cpha sweep 00, 01, 10, 11 -> masterDataReceived=8'hA5 in every mode; SCLK idle level equals cpol; exactly 8 leading and 8 trailing SCLK edges per transfer.
3. slaveSelect=2 -> only CS[2] low (CS=4'b1011) during the transfer. slaveSelect=3 then an out-of-range value (SLAVE_COUNT=3 build) -> CS stays 3'b111, busy stays 0, no done.
4. Second start issued at cycle 20 of a transfer -> ignored, single done. Start issued in the done cycle with 8'h3C -> second transfer begins next cycle and returns the looped value 8'h3C.
5. reset driven low asynchronously after 3 bits of 8'hFF -> same instant: CS all 1, SCLK=0, MOSI=0, busy=0, masterDataReceived=0, no done. A fresh transfer after release completes normally.
6. DATA_WIDTH=16, MSB_FIRST=0, CLK_DIV=1, loopback 16'h8001 -> first MOSI bit is 1 (LSB), received 16'h8001, done at cycle 35.
